vga_bar_renderer: RTL and testbench

- Pixel-colour generator for the bar-chart display: draws NUM_BARS vertical bars of individually programmable height, standing on a common baseline.
- Sits between vga_timing and the VGA pins. Consumes hcount/vcount/sync/blank; produces registered r/g/b/hs/vs, pipeline-aligned.
- Heights are double-buffered: a shadow set is written at any time and committed to the active set only at the vblank rising edge, so no frame tears.
- Up to two bars can be highlighted in a separate colour (e.g. bars being compared or swapped).

---
 rtl/vga_bar_if.sv | 43 ++++
 rtl/vga_bar_renderer.sv | 180 ++++++++++++++++++
 tb/tb_vga_bar_renderer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_bar_if.sv
// Signal bundle between the timing/control side and the bar renderer.
// Holds the video timing inputs, the height/commit/highlight controls and the pixel outputs.
interface vga_bar_if #(
  parameter int HW = 9,
  parameter int IW = 4
);
  logic [10:0]   hcount;
  logic [10:0]   vcount;
  logic          hsync_in;
  logic          vsync_in;
  logic          hblnk_in;
  logic          vblnk_in;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [HW-1:0] wr_height;
  logic          commit;
  logic [1:0]    hl_en;
  logic [IW-1:0] hl_idx_a;
  logic [IW-1:0] hl_idx_b;
  logic          hs;
  logic          vs;
  logic [3:0]    r;
  logic [3:0]    g;
  logic [3:0]    b;
  logic          commit_pending;
  logic          commit_done;
  // Commit FSM state: 0 = IDLE, 1 = PENDING.
  logic          fsm_state;

  // Handshake: wr_en and commit are single-cycle strobes, sampled on every pclk edge.
  // There is no ready/backpressure, so the renderer accepts every strobe it sees.
  modport master (
    output hcount, vcount, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output wr_en, wr_idx, wr_height, commit, hl_en, hl_idx_a, hl_idx_b,
    input  hs, vs, r, g, b, commit_pending, commit_done, fsm_state
  );

  modport slave (
    input  hcount, vcount, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  wr_en, wr_idx, wr_height, commit, hl_en, hl_idx_a, hl_idx_b,
    output hs, vs, r, g, b, commit_pending, commit_done, fsm_state
  );
endinterface

// File: rtl/vga_bar_renderer.sv
// Bar-chart pixel generator: double-buffered bar heights, optional highlight of two bars,
// and a 2-stage pipeline that keeps colour aligned with the delayed syncs.
module vga_bar_renderer #(
  parameter int          NUM_BARS = 8,
  parameter int          BAR_W    = 64,
  parameter int          BAR_GAP  = 32,
  parameter int          BASE_Y   = 570,
  parameter int          MAX_H    = 270,
  parameter int          HW       = 9,
  parameter int          IW       = 4,
  parameter logic [11:0] BG_RGB   = 12'haaa,
  parameter logic [11:0] BAR_RGB  = 12'hf00,
  parameter logic [11:0] HL_RGB   = 12'h0f0
) (
  input  logic      pclk,
  input  logic      rst,
  vga_bar_if.slave  bus
);

  localparam logic [11:0]   BASE  = 12'(BASE_Y);
  localparam logic [HW-1:0] HMAX  = HW'(MAX_H);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t        state, state_next;
  logic          copy;
  logic          vblnk_q;
  logic          vblank_rise;
  logic [HW-1:0] shadow [NUM_BARS];
  logic [HW-1:0] active [NUM_BARS];
  logic [HW-1:0] wr_clamped;

  logic [NUM_BARS-1:0] in_bar;
  logic                hit_c;
  logic [IW-1:0]       idx_c;

  logic          s1_hit;
  logic [IW-1:0] s1_idx;
  logic          s1_blank;
  logic          s1_hs;
  logic          s1_vs;
  logic [1:0]    s1_hl_en;
  logic [IW-1:0] s1_hl_a;
  logic [IW-1:0] s1_hl_b;

  logic          hs_q, vs_q;
  logic [11:0]   rgb_q;
  logic          pending_q, done_q;

  assign vblank_rise = bus.vblnk_in & ~vblnk_q;
  assign wr_clamped  = (bus.wr_height > HMAX) ? HMAX : bus.wr_height;

  // ---------------- commit FSM ----------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= IDLE;
      vblnk_q   <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      vblnk_q   <= bus.vblnk_in;
      pending_q <= (state_next == PENDING);
      done_q    <= copy;
    end
  end

  always_comb begin
    state_next = state;
    copy       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.commit) begin
          if (vblank_rise) copy = 1'b1;
          else             state_next = PENDING;
        end
      end
      PENDING: begin
        if (vblank_rise) begin
          copy       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- height registers ----------------
  // Nonblocking semantics make a copy see the shadow value from before this cycle's write.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (bus.wr_en && (bus.wr_idx == IW'(i))) shadow[i] <= wr_clamped;
        if (copy) active[i] <= shadow[i];
      end
    end
  end

  // ---------------- geometry ----------------
  for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
    localparam logic [11:0] XL = 12'(BAR_GAP + i * (BAR_W + BAR_GAP));
    localparam logic [11:0] XR = 12'(BAR_GAP + i * (BAR_W + BAR_GAP) + BAR_W);
    // Row test done as vcount + h >= BASE so a short bar never underflows.
    assign in_bar[i] = ({1'b0, bus.hcount} >= XL) &&
                       ({1'b0, bus.hcount} <  XR) &&
                       ({1'b0, bus.vcount} <  BASE) &&
                       (({1'b0, bus.vcount} + 12'(active[i])) >= BASE);
  end

  // Lowest index wins, although bars never overlap.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = NUM_BARS - 1; i >= 0; i--) begin
      if (in_bar[i]) begin
        hit_c = 1'b1;
        idx_c = IW'(i);
      end
    end
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
      s1_blank <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_hl_en <= '0;
      s1_hl_a  <= '0;
      s1_hl_b  <= '0;
    end else begin
      s1_hit   <= hit_c;
      s1_idx   <= idx_c;
      s1_blank <= bus.hblnk_in | bus.vblnk_in;
      s1_hs    <= bus.hsync_in;
      s1_vs    <= bus.vsync_in;
      s1_hl_en <= bus.hl_en;
      s1_hl_a  <= bus.hl_idx_a;
      s1_hl_b  <= bus.hl_idx_b;
    end
  end

  // ---------------- stage 2 ----------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      hs_q <= s1_hs;
      vs_q <= s1_vs;
      if (s1_blank)
        rgb_q <= 12'h000;
      else if (s1_hit && ((s1_hl_en[0] && (s1_idx == s1_hl_a)) ||
                          (s1_hl_en[1] && (s1_idx == s1_hl_b))))
        rgb_q <= HL_RGB;
      else if (s1_hit)
        rgb_q <= BAR_RGB;
      else
        rgb_q <= BG_RGB;
    end
  end

  assign bus.hs             = hs_q;
  assign bus.vs             = vs_q;
  assign bus.r              = rgb_q[11:8];
  assign bus.g              = rgb_q[7:4];
  assign bus.b              = rgb_q[3:0];
  assign bus.commit_pending = pending_q;
  assign bus.commit_done    = done_q;
  assign bus.fsm_state      = (state == PENDING);

endmodule

// File: tb/tb_vga_bar_renderer.sv
// Directed bench for vga_bar_renderer: heights, commit timing, highlight and pipeline alignment.
module tb_vga_bar_renderer;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vga_bar_if #(.HW(9), .IW(4)) bus ();

  vga_bar_renderer dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic pix(input int h, input int v);
    bus.hcount = 11'(h);
    bus.vcount = 11'(v);
  endtask

  task automatic write_h(input int idx, input int h);
    bus.wr_en     = 1'b1;
    bus.wr_idx    = 4'(idx);
    bus.wr_height = 9'(h);
    step(1);
    bus.wr_en     = 1'b0;
  endtask

  task automatic vblank_commit();
    bus.commit   = 1'b1;
    bus.vblnk_in = 1'b1;
    step(1);
    bus.commit   = 1'b0;
    bus.vblnk_in = 1'b0;
    step(1);
  endtask

  // ---------------- checkers ----------------
  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.r, bus.g, bus.b};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pix_chk(input string tag, input int h, input int v, input logic [11:0] exp);
    pix(h, v);
    step(2);
    chk_rgb(tag, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.hcount = '0;  bus.vcount = '0;
    bus.hsync_in = 0; bus.vsync_in = 0; bus.hblnk_in = 0; bus.vblnk_in = 0;
    bus.wr_en = 0;    bus.wr_idx = '0;  bus.wr_height = '0;
    bus.commit = 0;   bus.hl_en = '0;   bus.hl_idx_a = '0; bus.hl_idx_b = '0;
    step(2);
    rst = 1'b0;

    // Reset mid-frame with a commit pending
    write_h(0, 100);
    bus.commit = 1'b1;
    step(1);
    bus.commit = 1'b0;
    chk_bit("pending_before_rst", bus.commit_pending, 1'b1);
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    pix(40, 500);
    step(2);
    chk_bit("hs_before_rst", bus.hs, 1'b1);
    rst = 1'b1;
    step(1);
    chk_bit("rst_pending", bus.commit_pending, 1'b0);
    chk_rgb("rst_rgb", 12'h000);
    chk_bit("rst_hs", bus.hs, 1'b0);
    chk_bit("rst_vs", bus.vs, 1'b0);
    rst = 1'b0;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    bus.vblnk_in = 1'b1;
    step(1);
    chk_bit("rst_no_done", bus.commit_done, 1'b0);
    bus.vblnk_in = 1'b0;
    step(1);
    pix_chk("rst_bar_absent", 40, 500, 12'haaa);
    vblank_commit();
    pix_chk("rst_shadow_cleared", 40, 500, 12'haaa);

    // Bar 0 height 100, deferred commit
    write_h(0, 100);
    pix_chk("no_commit_yet", 40, 500, 12'haaa);
    bus.commit = 1'b1;
    step(1);
    bus.commit = 1'b0;
    chk_bit("pending_set", bus.commit_pending, 1'b1);
    chk_bit("fsm_pending", bus.fsm_state, 1'b1);
    bus.vblnk_in = 1'b1;
    step(1);
    chk_bit("done_pulse", bus.commit_done, 1'b1);
    chk_bit("pending_clr", bus.commit_pending, 1'b0);
    bus.vblnk_in = 1'b0;
    step(1);
    chk_bit("done_one_cycle", bus.commit_done, 1'b0);
    pix_chk("bar0_mid",     40, 500, 12'hf00);
    pix_chk("bar0_above",   40, 469, 12'haaa);
    pix_chk("bar0_top",     40, 470, 12'hf00);
    pix_chk("bar0_base",    40, 570, 12'haaa);
    pix_chk("bar0_left",    31, 500, 12'haaa);
    pix_chk("bar0_right",   95, 500, 12'hf00);
    pix_chk("bar0_past",    96, 500, 12'haaa);
    pix_chk("past_last",   800, 565, 12'haaa);

    // Clamp: 400 -> 270, commit in the vblank-rise cycle itself
    write_h(2, 400);
    bus.commit = 1'b1; bus.vblnk_in = 1'b1;
    step(1);
    chk_bit("imm_done", bus.commit_done, 1'b1);
    chk_bit("imm_not_pending", bus.commit_pending, 1'b0);
    bus.commit = 1'b0; bus.vblnk_in = 1'b0;
    step(1);
    pix_chk("clamp_top",   232, 300, 12'hf00);
    pix_chk("clamp_above", 232, 299, 12'haaa);

    // Highlight
    write_h(1, 50);
    write_h(2, 50);
    vblank_commit();
    bus.hl_en = 2'b01; bus.hl_idx_a = 4'd1;
    pix_chk("hl_a_bar1",  150, 560, 12'h0f0);
    pix_chk("hl_a_bar2",  240, 560, 12'hf00);
    pix_chk("hl_a_bg",    150, 510, 12'haaa);
    bus.hl_idx_a = 4'd9;
    pix_chk("hl_a_oob",   150, 560, 12'hf00);
    bus.hl_en = 2'b10; bus.hl_idx_b = 4'd2; bus.hl_idx_a = 4'd1;
    pix_chk("hl_b_bar2",  240, 560, 12'h0f0);
    pix_chk("hl_b_bar1",  150, 560, 12'hf00);
    bus.hl_en = 2'b00;
    pix_chk("hl_off",     240, 560, 12'hf00);

    // Pending commit, extra pulse, write collides with the copy
    bus.commit = 1'b1;
    step(1);
    bus.commit = 1'b0;
    step(3);
    chk_bit("pending_hold", bus.commit_pending, 1'b1);
    bus.commit = 1'b1;
    step(1);
    bus.commit = 1'b0;
    chk_bit("pending_extra", bus.commit_pending, 1'b1);
    bus.vblnk_in = 1'b1;
    bus.wr_en = 1'b1; bus.wr_idx = 4'd0; bus.wr_height = 9'd200;
    step(1);
    chk_bit("coll_done", bus.commit_done, 1'b1);
    bus.vblnk_in = 1'b0; bus.wr_en = 1'b0;
    step(1);
    pix_chk("coll_old_h_out", 40, 400, 12'haaa);
    pix_chk("coll_old_h_in",  40, 480, 12'hf00);
    vblank_commit();
    pix_chk("coll_new_h", 40, 400, 12'hf00);

    // Sync and blank pipeline alignment, inside bar 0 geometry
    pix_chk("align_base", 40, 560, 12'hf00);
    chk_bit("align_hs0", bus.hs, 1'b0);
    bus.hsync_in = 1'b1; bus.hblnk_in = 1'b1;
    step(1);
    chk_bit("hs_lat1", bus.hs, 1'b0);
    chk_rgb("blank_lat1", 12'hf00);
    step(1);
    chk_bit("hs_lat2", bus.hs, 1'b1);
    chk_rgb("blank_lat2", 12'h000);
    bus.hsync_in = 1'b0; bus.hblnk_in = 1'b0;
    step(1);
    chk_bit("hs_fall1", bus.hs, 1'b1);
    chk_rgb("unblank_lat1", 12'h000);
    step(1);
    chk_bit("hs_fall2", bus.hs, 1'b0);
    chk_rgb("unblank_lat2", 12'hf00);
    bus.vsync_in = 1'b1;
    step(1);
    chk_bit("vs_lat1", bus.vs, 1'b0);
    step(1);
    chk_bit("vs_lat2", bus.vs, 1'b1);
    bus.vsync_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
